decoder3_8_dispatch: RTL
========================

# decoder3_8_dispatch

Sequential 3:8 decoder and dispatcher: the receiving end of the 8:3 priority-encoded request path. It accepts a 3-bit channel code under a valid/ready handshake and drives a registered one-hot request to the selected channel. It holds that request until the channel acknowledges or a timeout expires. It sits downstream of the priority encoder and fans a single encoded grant out to eight consumer channels.

## Interface
Parameters:
- TIMEOUT, default 15: cycles a request may wait for acknowledge before it is abandoned; legal range 1..255.
- CNT_W, default 8: width of the dispatch counter.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_code  input  3  encoded channel index, 0..7.
- in_valid  input  1  in_code is valid.
- in_ready  output  1  block can accept a code this cycle.
- out_req  output  8  one-hot request, registered; bit in_code is set.
- out_ack  input  8  per-channel acknowledge; only the bit matching the active request is observed.
- busy  output  1  a request is outstanding.
- timeout_err  output  1  one-cycle pulse when a request is abandoned.
- dispatch_cnt  output  CNT_W  number of acknowledged dispatches, wraps modulo 2^CNT_W.

## Operation
- State machine: IDLE, DRIVE.
- Register reset values, applied asynchronously on rst_n low: state=IDLE, out_req=0, timeout_err=0, dispatch_cnt=0, captured code=0, timer=0.
- Combinational outputs: in_ready = (state==IDLE); busy = (state==DRIVE).
- IDLE behaviour:
  - On in_valid && in_ready, capture in_code, load out_req = 1<<in_code, clear the timer, and enter DRIVE.
  - in_valid low means no change.
- DRIVE behaviour:
  - out_req is held stable.
  - The timer increments every cycle.
  - If out_ack[code] is high, clear out_req, increment dispatch_cnt, and go to IDLE.
  - Otherwise, if timer == TIMEOUT-1, clear out_req, pulse timeout_err, and go to IDLE without counting.
- Acknowledges on non-selected bits are ignored in all states. Acknowledges in IDLE are ignored.
- When ack and timeout occur in the same cycle, ack wins: the dispatch is counted and there is no timeout_err.
- in_valid while busy is not accepted. The upstream block must hold in_code and in_valid until in_ready is high. The block does not check upstream stability.
- dispatch_cnt at its maximum value plus one ack wraps to 0.
- rst_n asserted mid-DRIVE drops out_req immediately, asynchronously, and returns to IDLE. There is no timeout_err on reset.

## Timing
- Accept on edge N: out_req is valid after edge N; busy is high and in_ready is low after N.
- Ack sampled high on edge M: out_req is 0 and in_ready is 1 after M. The earliest next accept is edge M+1, so the minimum handshake period is 2 cycles.
- Ack present on the first DRIVE edge (N+1) gives 2-cycle round trip.
- No ack: out_req stays high for exactly TIMEOUT cycles. timeout_err is high for the one cycle following edge N+TIMEOUT.
- timeout_err and dispatch_cnt are registered. There is no combinational path from out_ack to any output.

## Structure
- Shared package dispatch_pkg holds:
  - the state enum (IDLE, DRIVE);
  - the constant NCH=8;
  - the constant CODE_W=3.
- Sub-module decoder3_8 is a purely combinational 3-bit to 8-bit one-hot decoder. It is instanced once to form the next out_req value and to select the acknowledge bit (ack_sel = |(out_ack & out_req)).
- The top level holds the FSM, timer, counter and output registers.

## Test plan
- Reset, then code 5 with ack[5] high on the first DRIVE cycle.
  - Required response: out_req=8'h20 for 1 cycle, dispatch_cnt=1, in_ready high again 2 cycles after accept.
- Code 2 with ack[6] held high and ack[2] never raised, TIMEOUT=15.
  - Required response: out_req=8'h04 for exactly 15 cycles, one timeout_err pulse, dispatch_cnt unchanged.
- Code 7, then raise ack[7] on exactly the cycle where timer=TIMEOUT-1.
  - Required response: dispatch_cnt increments, timeout_err stays 0.
- in_valid held high with code 3 changing to 1 while busy.
  - Required response: in_ready=0, out_req stays 8'h08 until ack[3]; code 1 accepted only after return to IDLE.
- rst_n pulled low 4 cycles into DRIVE on code 0.
  - Required response: out_req=0 immediately (asynchronous), busy=0, timeout_err=0, dispatch_cnt=0.
- 256 back-to-back acked dispatches with CNT_W=8.
  - Required response: dispatch_cnt wraps to 0; one dispatch every 2 cycles.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared types and constants for the 3:8 dispatch path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dispatch_pkg;

  localparam int NCH    = 8;
  localparam int CODE_W = 3;

  // IDLE waits for a code; DRIVE holds a one-hot request until ack or expiry.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/decoder3_8.sv
// Combinational 3-bit code to 8-bit one-hot decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none, no handshake.
module decoder3_8
  import dispatch_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [NCH-1:0]    onehot
);

  // Exactly one bit set, selected by code.
  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/decoder3_8_dispatch.sv
// Accepts a channel code, drives a registered one-hot request until ack or timeout.
// Latency: out_req valid 1 edge after accept; ack sampled returns to idle on that edge.
// Backpressure: in_ready low while a request is outstanding; upstream must hold code/valid.
module decoder3_8_dispatch
  import dispatch_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [NCH-1:0]    out_req,
  input  logic [NCH-1:0]    out_ack,
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  dispatch_cnt
);

  // Timer is wide enough for the full legal TIMEOUT range (1..255).
  localparam int               TMR_W    = 8;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t            state;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] dec_code;
  logic [NCH-1:0]    dec_onehot;
  logic [TMR_W-1:0]  timer;
  logic              accept;
  logic              ack_sel;

  assign in_ready = (state == IDLE);
  assign busy     = (state == DRIVE);
  assign accept   = in_valid && in_ready;

  // One decoder serves both jobs: while idle it forms the next request from
  // in_code; while driving it re-decodes the captured code, which equals
  // out_req, to pick the single acknowledge bit that matters.
  assign dec_code = busy ? code_q : in_code;

  decoder3_8 u_dec (
    .code   (dec_code),
    .onehot (dec_onehot)
  );

  assign ack_sel = busy && (|(out_ack & dec_onehot));

  // FSM, timer, counter and output registers; ack takes priority over expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      out_req      <= '0;
      timeout_err  <= 1'b0;
      dispatch_cnt <= '0;
      code_q       <= '0;
      timer        <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            code_q  <= in_code;
            out_req <= dec_onehot;
            timer   <= '0;
            state   <= DRIVE;
          end
        end
        DRIVE: begin
          timer <= timer + TMR_W'(1);
          if (ack_sel) begin
            out_req      <= '0;
            dispatch_cnt <= dispatch_cnt + CNT_W'(1);
            state        <= IDLE;
          end else if (timer == TMR_LAST) begin
            out_req     <= '0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
